// File: rtl/dualport_ram_ext.sv
// Parametrised true dual-port RAM with registered reads, port-1-wins write
// arbitration and a post-reset clear engine. Macro DPRAM_BYPASS_EN selects write-first reads.
module dualport_ram_ext #(
  parameter int                 DATA_W    = 16,
  parameter int                 ADDR_W    = 9,
  parameter logic [DATA_W-1:0]  CLEAR_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              write_en1,
  input  logic              write_en2,
  input  logic              read_en1,
  input  logic              read_en2,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [ADDR_W-1:0] addr2,
  input  logic [DATA_W-1:0] Data_in1,
  input  logic [DATA_W-1:0] Data_in2,
  output logic [DATA_W-1:0] Data_out1,
  output logic [DATA_W-1:0] Data_out2,
  output logic              rd_valid1,
  output logic              rd_valid2,
  output logic              busy,
  output logic              collision,
  output logic              dbg_state
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W + 1)'(DEPTH - 1);

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0]   data_out1_q, data_out1_d;
  logic [DATA_W-1:0]   data_out2_q, data_out2_d;
  logic                rd_valid1_q, rd_valid1_d;
  logic                rd_valid2_q, rd_valid2_d;
  logic                collision_q, collision_d;

  logic [DATA_W-1:0]   mem_q [DEPTH];

  // Write port A carries the clear engine in CLEAR and port 1 in RUN;
  // write port B carries port 2 and is suppressed when port 1 owns the address.
  logic                wa_en, wb_en;
  logic [ADDR_W-1:0]   wa_addr;
  logic [DATA_W-1:0]   wa_data;
  logic                rd_en1, rd_en2, same_addr;
  logic [DATA_W-1:0]   rd_word1, rd_word2;

  // Requests carry no handshake: a read_enN/write_enN sampled high while
  // RUN is serviced on that edge, and rd_validN marks the one cycle in
  // which Data_outN was refreshed by it. While busy, requests are dropped.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wa_en     = 1'b0;
    wb_en     = 1'b0;
    wa_addr   = addr1;
    wa_data   = Data_in1;
    rd_en1    = 1'b0;
    rd_en2    = 1'b0;
    same_addr = (addr1 == addr2);

    case (state_q)
      CLEAR: begin
        wa_en   = 1'b1;
        wa_addr = cnt_q[ADDR_W-1:0];
        wa_data = CLEAR_VAL;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_ADDR) state_d = RUN;
      end
      RUN: begin
        wa_en  = write_en1;
        wb_en  = write_en2 && !(write_en1 && same_addr);
        rd_en1 = read_en1;
        rd_en2 = read_en2;
      end
      default: state_d = CLEAR;
    endcase

    if (rst) begin
      wa_en  = 1'b0;
      wb_en  = 1'b0;
      rd_en1 = 1'b0;
      rd_en2 = 1'b0;
    end
  end

`ifdef DPRAM_BYPASS_EN
  // Write-first: port A is checked first so port 1's data wins a collision.
  always_comb begin
    rd_word1 = mem_q[addr1];
    if (wa_en && (wa_addr == addr1))      rd_word1 = wa_data;
    else if (wb_en && (addr2 == addr1))   rd_word1 = Data_in2;
    rd_word2 = mem_q[addr2];
    if (wa_en && (wa_addr == addr2))      rd_word2 = wa_data;
    else if (wb_en)                       rd_word2 = Data_in2;
  end
`else
  // Read-first: the array is read before this edge's writes land.
  always_comb begin
    rd_word1 = mem_q[addr1];
    rd_word2 = mem_q[addr2];
  end
`endif

  always_comb begin
    rd_valid1_d = rd_en1;
    rd_valid2_d = rd_en2;
    data_out1_d = rd_en1 ? rd_word1 : data_out1_q;
    data_out2_d = rd_en2 ? rd_word2 : data_out2_q;
    collision_d = (state_q == RUN) && write_en1 && write_en2 && same_addr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= CLEAR;
      cnt_q       <= '0;
      data_out1_q <= '0;
      data_out2_q <= '0;
      rd_valid1_q <= 1'b0;
      rd_valid2_q <= 1'b0;
      collision_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      data_out1_q <= data_out1_d;
      data_out2_q <= data_out2_d;
      rd_valid1_q <= rd_valid1_d;
      rd_valid2_q <= rd_valid2_d;
      collision_q <= collision_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wa_en) mem_q[wa_addr] <= wa_data;
    if (wb_en) mem_q[addr2]   <= Data_in2;
  end

  assign Data_out1 = data_out1_q;
  assign Data_out2 = data_out2_q;
  assign rd_valid1 = rd_valid1_q;
  assign rd_valid2 = rd_valid2_q;
  assign collision = collision_q;
  assign busy      = (state_q == CLEAR);
  assign dbg_state = state_q;

endmodule
